mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Load/store master that sits between the MIPS MEM stage and the word-organised data memory.
- The data memory has a synchronous single-port interface: one address, one write strobe (1 = write, 0 = read), and a registered read data output valid one cycle after the address.
- This block accepts byte, halfword and word loads/stores at byte addresses. It performs alignment and sign/zero extension, and does read-modify-write for sub-word stores.
- It is the only agent driving the data memory port.

Parameters:
- DATA_WIDTH, 32, memory word width in bits; only 32 is supported.
- ADDR_WIDTH, 10, memory word-address width (1024 words).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  high only in IDLE; request accepted on an edge where req_valid && req_ready
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as error)
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- rsp_valid  output  1  one-cycle completion pulse
- rsp_err  output  1  qualifies rsp_valid: misaligned or reserved size, no memory access made
- rsp_rdata  output  32  load result; 0 for stores and errors
- mem_addr  output  ADDR_WIDTH  word address = req_addr[ADDR_WIDTH+1:2]; upper bits ignored (wrap)
- mem_din  output  DATA_WIDTH  write data to memory
- mem_wr_rd  output  1  memory write strobe
- mem_dout  input  DATA_WIDTH  memory read data, valid one edge after mem_addr with mem_wr_rd = 0

Behaviour:
- Reset values (all outputs registered): rsp_valid 0, rsp_err 0, rsp_rdata 0, mem_addr 0, mem_din 0, mem_wr_rd 0, state IDLE.
- Reset mid-operation aborts the operation:
  - no response is produced;
  - mem_wr_rd falls immediately;
  - a write not yet clocked into memory is lost.
- Byte order is little-endian: lane = addr[1:0], byte 0 = bits 7:0.
- Halfword alignment requires addr[0] = 0; word alignment requires addr[1:0] = 0.
- Accepted request fields are latched; inputs are don't-care while busy.
- State machine (edges relative to the accept edge E0):
  - IDLE, misaligned or size 11: at E0, rsp_valid=1 and rsp_err=1; state stays IDLE; no memory access.
  - IDLE, load: at E0, mem_addr set, mem_wr_rd=0, go to LD_WAIT.
  - LD_WAIT: at E1, memory registers mem_dout; go to LD_CAP.
  - LD_CAP: at E2, rsp_rdata = extracted and extended lane(s) of mem_dout, rsp_valid=1; go to IDLE.
  - IDLE, word store: at E0, mem_addr, mem_din = req_wdata and mem_wr_rd=1 are set; go to ST_WR.
  - ST_WR: at the next edge the memory writes; mem_wr_rd=0, rsp_valid=1; go to IDLE.
  - IDLE, byte/half store: at E0, mem_addr set, mem_wr_rd=0; go to RMW_WAIT; E1 goes to RMW_MRG.
  - RMW_MRG: at E2, mem_din = mem_dout with the target lane(s) replaced by req_wdata[7:0] or [15:0], mem_wr_rd=1; go to ST_WR (write at E3, response after E3).
- Latency from acceptance to rsp_valid:
  - error: 1 edge
  - word store: 2 edges
  - load: 3 edges
  - sub-word store: 4 edges
- rsp_valid pulses in the first IDLE cycle with req_ready=1, so back-to-back requests are allowed.
- mem_wr_rd is high for exactly one cycle per store and never high for loads or errors.

Decomposition:
- Package mips_mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - the FSM state enum (IDLE, LD_WAIT, LD_CAP, RMW_WAIT, RMW_MRG, ST_WR);
  - the alignment-check function.
- Sub-module mem_lane_align is purely combinational. It computes load extraction/extension and store merge from (word, offset, size, signed, wdata).

Test Plan:
- Word store 0xDEADBEEF at 0x10: mem_addr=4, mem_din=0xDEADBEEF, mem_wr_rd high one cycle, rsp_valid 2 edges after accept. Word load at 0x10 then returns 0xDEADBEEF 3 edges after accept.
- Byte loads from the same word:
  - signed at 0x11 -> 0xFFFFFFBE;
  - unsigned at 0x11 -> 0x000000BE;
  - signed half at 0x12 -> 0xFFFFDEAD;
  - unsigned half at 0x10 -> 0x0000BEEF.
- Byte store 0x55 at 0x13 -> single write of 0x55ADBEEF to word 4, rsp_valid 4 edges after accept. A following word load returns 0x55ADBEEF.
- Misaligned half at 0x11, word at 0x12, size 11 -> each gives rsp_valid=rsp_err=1 after 1 edge, mem_wr_rd stays 0, memory unchanged.
- req_valid held with 3 consecutive loads -> req_ready low in busy states, one acceptance every 3 cycles, responses in order with correct data.
- rst_n pulsed low during RMW_MRG and during ST_WR -> all outputs 0 immediately, no rsp_valid after release, next request serviced normally.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types for the MEM-stage load/store master:
// size codes, FSM states and the alignment rule.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LD_WAIT,
    LD_CAP,
    RMW_WAIT,
    RMW_MRG,
    ST_WR
  } state_t;

  // Reserved size 11 is reported as misaligned.
  function automatic logic is_aligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~off[0];
      SZ_WORD: ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus data memory port.
// master = load/store unit, slave = CPU + memory side.
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic                  rsp_err;
  logic [31:0]           rsp_rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic                  mem_wr_rd;
  logic [DATA_WIDTH-1:0] mem_dout;

  modport master (
    input  req_valid, req_we, req_size,
    input  req_signed, req_addr, req_wdata,
    input  mem_dout,
    output req_ready, rsp_valid, rsp_err,
    output rsp_rdata, mem_addr, mem_din,
    output mem_wr_rd
  );

  modport slave (
    output req_valid, req_we, req_size,
    output req_signed, req_addr, req_wdata,
    output mem_dout,
    input  req_ready, rsp_valid, rsp_err,
    input  rsp_rdata, mem_addr, mem_din,
    input  mem_wr_rd
  );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane extract/extend for loads and
// lane merge for sub-word stores (combinational).
module mem_lane_align (
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);
  import mips_mem_pkg::*;

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_off, 3'b000} +: 8];
  assign w_half = i_off[1] ? i_word[31:16]
                           : i_word[15:0];

  always_comb begin
    o_load  = '0;
    o_merge = i_word;
    unique case (i_size)
      SZ_BYTE: begin
        o_load = {{24{i_signed & w_byte[7]}}, w_byte};
        o_merge[{i_off, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        o_load = {{16{i_signed & w_half[15]}}, w_half};
        o_merge[{i_off[1], 4'b0000} +: 16] = i_wdata;
      end
      SZ_WORD: o_load = i_word;
      default: o_load = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store master for a synchronous word memory:
// alignment, extension and read-modify-write sub-word stores.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input logic             clk,
  input logic             rst_n,
  mem_access_unit_if.master bus
);
  import mips_mem_pkg::*;

  state_t                r_state, w_state;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [1:0]            r_off;
  logic [15:0]           r_wdata;
  logic                  r_rsp_valid, w_rsp_valid;
  logic                  r_rsp_err, w_rsp_err;
  logic [31:0]           r_rsp_rdata, w_rsp_rdata;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_din, w_mem_din;
  logic                  r_mem_wr_rd, w_mem_wr_rd;
  logic                  w_latch;
  logic [31:0]           w_load, w_merge;
  logic [1:0]            w_off;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic                  w_unused_addr;

  assign w_off   = bus.req_addr[1:0];
  assign w_waddr = bus.req_addr[ADDR_WIDTH+1:2];
  // Upper address bits wrap onto the memory.
  assign w_unused_addr =
    &{1'b0, bus.req_addr[31:ADDR_WIDTH+2]};

  mem_lane_align u_align (
    .i_word   (bus.mem_dout),
    .i_off    (r_off),
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  always_comb begin
    w_state     = r_state;
    w_rsp_valid = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_rdata = '0;
    w_mem_addr  = r_mem_addr;
    w_mem_din   = r_mem_din;
    w_mem_wr_rd = 1'b0;
    w_latch     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_latch = 1'b1;
          if (!is_aligned(bus.req_size, w_off)) begin
            w_rsp_valid = 1'b1;
            w_rsp_err   = 1'b1;
          end else begin
            w_mem_addr = w_waddr;
            if (!bus.req_we) begin
              w_state = LD_WAIT;
            end else if (bus.req_size == SZ_WORD) begin
              w_mem_din   = bus.req_wdata;
              w_mem_wr_rd = 1'b1;
              w_state     = ST_WR;
            end else begin
              w_state = RMW_WAIT;
            end
          end
        end
      end
      LD_WAIT:  w_state = LD_CAP;
      LD_CAP: begin
        w_rsp_valid = 1'b1;
        w_rsp_rdata = w_load;
        w_state     = IDLE;
      end
      RMW_WAIT: w_state = RMW_MRG;
      RMW_MRG: begin
        w_mem_din   = w_merge;
        w_mem_wr_rd = 1'b1;
        w_state     = ST_WR;
      end
      ST_WR: begin
        w_rsp_valid = 1'b1;
        w_state     = IDLE;
      end
      default:  w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_size      <= '0;
      r_signed    <= 1'b0;
      r_off       <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
      r_mem_wr_rd <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
      r_rsp_rdata <= w_rsp_rdata;
      r_mem_addr  <= w_mem_addr;
      r_mem_din   <= w_mem_din;
      r_mem_wr_rd <= w_mem_wr_rd;
      if (w_latch) begin
        r_size   <= bus.req_size;
        r_signed <= bus.req_signed;
        r_off    <= w_off;
        r_wdata  <= bus.req_wdata[15:0];
      end
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_din   = r_mem_din;
  assign bus.mem_wr_rd = r_mem_wr_rd;

endmodule
